load_store_unit: RTL

- Sits between the execute stage and the word-addressed data memory.
- Turns byte, halfword and word loads/stores (signed and unsigned) into whole-word memory accesses.
- Sub-word stores use a read-modify-write sequence; loads get lane extraction and sign/zero extension.
- Raises `busy` to stall the pipeline while an access is in flight.

---
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - execute-side request/response and word-memory port bundle for load_store_unit
interface load_store_unit_if #(parameter int WIDTH = 32);
    logic             req;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             busy;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             misalign;
    logic [WIDTH-1:0] mem_A;
    logic [WIDTH-1:0] mem_WD;
    logic             mem_WE;
    logic [WIDTH-1:0] mem_RD;

    modport master (
        output req, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_RD,
        input  busy, rsp_valid, rsp_rdata, misalign, mem_A, mem_WD, mem_WE
    );

    modport slave (
        input  req, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_RD,
        output busy, rsp_valid, rsp_rdata, misalign, mem_A, mem_WD, mem_WE
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit over word memory, sub-word stores via read-modify-write
// Optional misaligned-request trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LOAD, WR, RMW_RD, RMW_WR} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] addr_q, wdata_q, merged_q, merged_d, rdata_ext;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_rdata_q;
    logic             accept, misaligned;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;

    assign accept = bus.req && (state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
    assign bus.misalign = misalign_q;
`else
    assign misaligned   = 1'b0;
    assign bus.misalign = 1'b0;
`endif

    assign bus.mem_A     = {2'b00, addr_q[WIDTH-1:2]};
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // mem_WE is decoded from state alone so an async reset kills it at once
    always_comb begin
        state_next = state;
        bus.busy   = (state != IDLE);
        bus.mem_WE = 1'b0;
        bus.mem_WD = '0;
        case (state)
            IDLE: begin
                if (accept && !misaligned) begin
                    if (!bus.req_we)          state_next = LOAD;
                    else if (bus.req_size[1]) state_next = WR;
                    else                      state_next = RMW_RD;
                end
            end
            LOAD:   state_next = IDLE;
            WR: begin
                bus.mem_WE = 1'b1;
                bus.mem_WD = wdata_q;
                state_next = IDLE;
            end
            RMW_RD: state_next = RMW_WR;
            RMW_WR: begin
                bus.mem_WE = 1'b1;
                bus.mem_WD = merged_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_byte = 8'h00;
        case (addr_q[1:0])
            2'd0: rd_byte = bus.mem_RD[7:0];
            2'd1: rd_byte = bus.mem_RD[15:8];
            2'd2: rd_byte = bus.mem_RD[23:16];
            2'd3: rd_byte = bus.mem_RD[31:24];
            default: rd_byte = 8'h00;
        endcase
        rd_half = addr_q[1] ? bus.mem_RD[31:16] : bus.mem_RD[15:0];
        case (size_q)
            2'b00:   rdata_ext = {{(WIDTH-8){rd_byte[7] & ~uns_q}}, rd_byte};
            2'b01:   rdata_ext = {{(WIDTH-16){rd_half[15] & ~uns_q}}, rd_half};
            default: rdata_ext = bus.mem_RD;
        endcase
    end

    always_comb begin
        merged_d = bus.mem_RD;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged_d[7:0]   = wdata_q[7:0];
                2'd1: merged_d[15:8]  = wdata_q[7:0];
                2'd2: merged_d[23:16] = wdata_q[7:0];
                2'd3: merged_d[31:24] = wdata_q[7:0];
                default: merged_d = bus.mem_RD;
            endcase
        end else if (addr_q[1]) begin
            merged_d[31:16] = wdata_q[15:0];
        end else begin
            merged_d[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            merged_q    <= '0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= accept && misaligned;
`endif
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
            end
            if (state == LOAD) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rdata_ext;
            end
            if (state == RMW_RD) merged_q <= merged_d;
        end
    end
endmodule
